syn_io_ctrl: RTL and testbench

- Parametrised next-generation synapse-array I/O controller on the client side of the synapse I/O port.
- Generalised in data width, channel count, pattern count and result buffering.
- Accepts commands from the processor side, runs a start/busy transaction towards the synapse block, and captures tagged results from NUM_CH channels into a result FIFO.
- The FIFO is read by the processor with a valid/ready handshake.

---
 rtl/syn_io_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_syn_io_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/syn_io_ctrl.sv
`default_nettype none
// ============================================================================
// syn_io_ctrl : client-side synapse I/O controller. Runs start/busy command
//               transactions and buffers tagged results in a FIFO.
//               Optional watchdog: define SYN_IO_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_io_ctrl #(
   parameter int DW          = 32,
   parameter int NUM_CH      = 2,
   parameter int NUM_PAT     = 4,
   parameter int PAT_W       = 8,
   parameter int OP_W        = 3,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PC_W       = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   localparam int FW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [OP_W-1:0]          cmd_op,
   input  logic [DW-1:0]            cmd_data,
   input  logic [NUM_PAT*PAT_W-1:0] cmd_patterns,
   output logic                     syn_start,
   output logic [OP_W-1:0]          syn_op,
   input  logic                     syn_busy,
   output logic                     c2s_valid,
   output logic [DW-1:0]            c2s_data,
   output logic [NUM_PAT*PAT_W-1:0] c2s_patterns,
   input  logic                     s2c_valid,
   input  logic [DW-1:0]            s2c_data,
   input  logic [CH_W-1:0]          s2c_channel,
   input  logic [PC_W-1:0]          s2c_pat_ctr,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DW-1:0]            res_data,
   output logic [CH_W-1:0]          res_channel,
   output logic [PC_W-1:0]          res_pat,
   output logic [FW-1:0]            fill,
   output logic                     overflow,
   output logic                     err_timeout,
   input  logic                     err_clr
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_EW = CH_W + PC_W + DW;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_START    = 2'd1,
      S_WAIT_ACK = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
         $error("syn_io_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
      end
   endgenerate

   state_t                     r_state;
   logic                       r_syn_start;
   logic                       r_c2s_valid;
   logic [OP_W-1:0]            r_syn_op;
   logic [DW-1:0]              r_c2s_data;
   logic [NUM_PAT*PAT_W-1:0]   r_c2s_patterns;
   logic                       r_overflow;
   logic                       r_err_timeout;
   logic                       w_cmd_fire;
   logic                       w_timeout;

   assign cmd_ready    = (r_state == S_IDLE) && !syn_busy;
   assign w_cmd_fire   = cmd_valid && cmd_ready;
   assign syn_start    = r_syn_start;
   assign c2s_valid    = r_c2s_valid;
   assign syn_op       = r_syn_op;
   assign c2s_data     = r_c2s_data;
   assign c2s_patterns = r_c2s_patterns;
   assign overflow     = r_overflow;
   assign err_timeout  = r_err_timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_syn_start    <= 1'b0;
         r_c2s_valid    <= 1'b0;
         r_syn_op       <= '0;
         r_c2s_data     <= '0;
         r_c2s_patterns <= '0;
      end else begin
         r_syn_start <= 1'b0;
         r_c2s_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_syn_op       <= cmd_op;
                  r_c2s_data     <= cmd_data;
                  r_c2s_patterns <= cmd_patterns;
                  r_syn_start    <= 1'b1;
                  r_c2s_valid    <= 1'b1;
                  r_state        <= S_START;
               end
            end
            S_START:    r_state <= S_WAIT_ACK;
            S_WAIT_ACK: begin
               if (w_timeout)     r_state <= S_IDLE;
               else if (syn_busy) r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_timeout || !syn_busy) r_state <= S_IDLE;
            end
            default:    r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SYN_IO_TIMEOUT_EN
   localparam int c_TW = $clog2(TIMEOUT_CYC) + 1;
   logic [c_TW-1:0] r_wd_cnt;

   // START is the only way into WAIT_ACK, so clearing there restarts the count on entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_wd_cnt <= '0;
      else if (r_state == S_START)
         r_wd_cnt <= '0;
      else if ((r_state == S_WAIT_ACK || r_state == S_RUN) && !w_timeout)
         r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   assign w_timeout = (r_state == S_WAIT_ACK || r_state == S_RUN) &&
                      (r_wd_cnt == c_TW'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------- result FIFO
   logic [c_EW-1:0]  r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [FW-1:0]    r_fill;
   logic [c_EW-1:0]  w_head;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full    = (r_fill == FW'(FIFO_DEPTH));
   assign res_valid = (r_fill != '0);
   assign w_pop     = res_valid && res_ready;
   assign w_push    = s2c_valid && (!w_full || w_pop);
   assign fill      = r_fill;

   // Head is masked while empty so stale storage never reaches the outputs
   assign w_head      = res_valid ? r_mem[r_rd_ptr] : '0;
   assign res_data    = w_head[DW-1:0];
   assign res_pat     = w_head[DW +: PC_W];
   assign res_channel = w_head[DW+PC_W +: CH_W];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {s2c_channel, s2c_pat_ctr, s2c_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Sticky flags: a set event in the clear cycle takes priority
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         if (s2c_valid && !w_push) r_overflow <= 1'b1;
         else if (err_clr)         r_overflow <= 1'b0;
         if (w_timeout)            r_err_timeout <= 1'b1;
         else if (err_clr)         r_err_timeout <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_syn_io_ctrl.sv
`default_nettype none
// tb_syn_io_ctrl : scoreboard bench for syn_io_ctrl; driver pushes expected
// results into a queue, a negedge monitor pops and compares on every FIFO pop.
module tb_syn_io_ctrl;
   localparam int DW = 32, NUM_CH = 2, NUM_PAT = 4, PAT_W = 8, OP_W = 3;
   localparam int DEPTH = 8, TOUT = 16;
   localparam int CH_W = 1, PC_W = 2, FW = 4, EW = CH_W + PC_W + DW;

   logic clk = 1'b0, reset = 1'b1;
   logic cmd_valid = 0, cmd_ready;
   logic [OP_W-1:0] cmd_op = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [NUM_PAT*PAT_W-1:0] cmd_patterns = '0;
   logic syn_start, syn_busy = 0, c2s_valid;
   logic [OP_W-1:0] syn_op;
   logic [DW-1:0] c2s_data;
   logic [NUM_PAT*PAT_W-1:0] c2s_patterns;
   logic s2c_valid = 0;
   logic [DW-1:0] s2c_data = '0;
   logic [CH_W-1:0] s2c_channel = '0;
   logic [PC_W-1:0] s2c_pat_ctr = '0;
   logic res_valid, res_ready = 0;
   logic [DW-1:0] res_data;
   logic [CH_W-1:0] res_channel;
   logic [PC_W-1:0] res_pat;
   logic [FW-1:0] fill;
   logic overflow, err_timeout, err_clr = 0;

   syn_io_ctrl #(.DW(DW), .NUM_CH(NUM_CH), .NUM_PAT(NUM_PAT), .PAT_W(PAT_W), .OP_W(OP_W),
                 .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_patterns(cmd_patterns), .syn_start(syn_start), .syn_op(syn_op),
      .syn_busy(syn_busy), .c2s_valid(c2s_valid), .c2s_data(c2s_data), .c2s_patterns(c2s_patterns),
      .s2c_valid(s2c_valid), .s2c_data(s2c_data), .s2c_channel(s2c_channel), .s2c_pat_ctr(s2c_pat_ctr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_channel(res_channel),
      .res_pat(res_pat), .fill(fill), .overflow(overflow), .err_timeout(err_timeout), .err_clr(err_clr));

   always #5 clk = ~clk;

   int n_checks = 0, n_err = 0;
   logic [EW-1:0] exp_q[$];
   int  m_fill = 0;
   bit  m_ovf = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of result traffic, update the reference FIFO, advance past the edge
   task automatic cyc(input bit v, input logic [CH_W-1:0] ch, input logic [PC_W-1:0] pat,
                      input logic [DW-1:0] d, input bit rdy);
      bit pop, acc;
      s2c_valid = v; s2c_channel = ch; s2c_pat_ctr = pat; s2c_data = d; res_ready = rdy;
      pop = (m_fill > 0) && rdy;
      acc = v && ((m_fill < DEPTH) || pop);
      if (acc) exp_q.push_back({ch, pat, d});
      if (v && !acc) m_ovf = 1;
      else if (err_clr) m_ovf = 0;
      m_fill = m_fill + int'(acc) - int'(pop);
      @(posedge clk); #1;
      chk("fill", 64'(fill), 64'(m_fill));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("res_valid", 64'(res_valid), 64'(m_fill != 0));
   endtask

   task automatic idle();
      cyc(0, '0, '0, '0, 0);
   endtask

   task automatic cyc_r();
      cyc(1'($urandom_range(0, 1)), CH_W'($urandom), PC_W'($urandom), $urandom, 1'($urandom_range(0, 1)));
   endtask

   // Monitor: every pop the DUT is about to perform must match the oldest expected result
   always @(negedge clk) begin
      if (reset && res_valid && res_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h expected no entry", {res_channel, res_pat, res_data});
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            if ({res_channel, res_pat, res_data} !== e) begin
               n_err++;
               $display("FAIL pop_entry: got 0x%0h expected 0x%0h at %0t",
                        {res_channel, res_pat, res_data}, e, $time);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic issue(input logic [OP_W-1:0] op, input logic [DW-1:0] d,
                        input logic [NUM_PAT*PAT_W-1:0] p, input bit rnd);
      cmd_valid = 1; cmd_op = op; cmd_data = d; cmd_patterns = p;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      if (rnd) cyc_r(); else idle();
      cmd_valid = 0;
      chk("syn_start", 64'(syn_start), 64'd1);
      chk("c2s_valid", 64'(c2s_valid), 64'd1);
      chk("syn_op", 64'(syn_op), 64'(op));
      chk("c2s_data", 64'(c2s_data), 64'(d));
      chk("c2s_patterns", 64'(c2s_patterns), 64'(p));
      chk("cmd_ready_start", 64'(cmd_ready), 64'd0);
   endtask

   initial begin
      #1 reset = 0;
      #2;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_outputs", {syn_start, c2s_valid, res_valid, overflow, err_timeout, fill}, 64'd0);
      chk("rst_syn_op", 64'(syn_op), 64'd0);
      chk("rst_c2s_data", 64'(c2s_data), 64'd0);
      chk("rst_c2s_pat", 64'(c2s_patterns), 64'd0);
      chk("rst_res", {res_channel, res_pat, res_data}, 64'd0);
      @(posedge clk); #1 reset = 1;

      // Directed command with busy handshake
      issue(3'd3, 32'hDEADBEEF, 32'h04030201, 0);
      idle();
      chk("start_pulse", 64'({syn_start, c2s_valid}), 64'd0);
      chk("c2s_data_hold", 64'(c2s_data), 64'hDEADBEEF);
      syn_busy = 1;
      for (int i = 0; i < 10; i++) begin
         idle();
         chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      end
      syn_busy = 0;
      idle();
      chk("cmd_ready_done", 64'(cmd_ready), 64'd1);

      // Four results buffered, then drained in order
      for (int i = 0; i < 4; i++) cyc(1, CH_W'(i % 2), PC_W'(i), 32'h10 + i, 0);
      chk("fill4", 64'(fill), 64'd4);
      for (int i = 0; i < 4; i++) idle_rdy();
      chk("drained4", 64'(res_valid), 64'd0);

      // Overflow, clear, push+pop while full, set-wins-over-clear
      for (int i = 0; i < 9; i++) cyc(1, CH_W'(i), PC_W'(i), 32'h20 + i, 0);
      chk("full_fill", 64'(fill), 64'(DEPTH));
      chk("full_ovf", 64'(overflow), 64'd1);
      err_clr = 1; idle(); err_clr = 0;
      chk("ovf_cleared", 64'(overflow), 64'd0);
      cyc(1, 1'b1, 2'd3, 32'h55, 1);
      chk("full_pushpop", 64'(fill), 64'(DEPTH));
      err_clr = 1; cyc(1, 1'b0, 2'd1, 32'h66, 0); err_clr = 0;
      chk("ovf_set_wins", 64'(overflow), 64'd1);
      err_clr = 1; idle(); err_clr = 0;
      for (int i = 0; i < DEPTH; i++) idle_rdy();
      chk("queue_empty1", 64'(exp_q.size()), 64'd0);

      // Randomised commands with background result traffic
      for (int n = 0; n < 8; n++) begin
         logic [OP_W-1:0] op; logic [DW-1:0] d; logic [NUM_PAT*PAT_W-1:0] p;
         int dly, len;
         op = OP_W'($urandom); d = $urandom; p = $urandom;
         dly = $urandom_range(0, 3); len = $urandom_range(1, 5);
         issue(op, d, p, 1);
         for (int i = 0; i < dly + 1; i++) begin
            cyc_r();
            chk("rnd_no_start", 64'({syn_start, cmd_ready}), 64'd0);
         end
         syn_busy = 1;
         for (int i = 0; i < len; i++) cyc_r();
         syn_busy = 0;
         cyc_r();
         chk("rnd_ready", 64'(cmd_ready), 64'd1);
         chk("rnd_hold", {c2s_data, c2s_patterns}, {d, p});
      end
      for (int i = 0; i < DEPTH + 2; i++) idle_rdy();
      chk("queue_empty2", 64'(exp_q.size()), 64'd0);
      err_clr = 1; idle(); err_clr = 0;

      // Watchdog behaviour with a command that never sees busy
      issue(3'd5, 32'h1234, 32'h0, 0);
`ifdef SYN_IO_TIMEOUT_EN
      for (int i = 0; i < TOUT; i++) begin
         idle();
         chk("to_wait", 64'(cmd_ready), 64'd0);
      end
      idle();
      chk("to_idle", 64'(cmd_ready), 64'd1);
      chk("to_err", 64'(err_timeout), 64'd1);
      err_clr = 1; idle(); err_clr = 0;
      chk("to_err_clr", 64'(err_timeout), 64'd0);
`else
      for (int i = 0; i < 100; i++) begin
         idle();
         chk("no_to_wait", 64'(cmd_ready), 64'd0);
      end
      chk("no_to_err", 64'(err_timeout), 64'd0);
      syn_busy = 1; idle(); syn_busy = 0; idle();
      chk("no_to_idle", 64'(cmd_ready), 64'd1);
`endif

      // Asynchronous reset while running with three buffered results
      issue(3'd1, 32'hCAFE, 32'h0, 0);
      idle();
      syn_busy = 1;
      for (int i = 0; i < 3; i++) cyc(1, 1'b1, PC_W'(i), 32'h70 + i, 0);
      chk("pre_rst_fill", 64'(fill), 64'd3);
      #2 syn_busy = 0; reset = 0;
      exp_q.delete(); m_fill = 0; m_ovf = 0;
      #1;
      chk("arst_fill", 64'(fill), 64'd0);
      chk("arst_res_valid", 64'(res_valid), 64'd0);
      chk("arst_idle", 64'(cmd_ready), 64'd1);
      chk("arst_regs", {syn_op, c2s_data}, 64'd0);
      @(posedge clk); #1 reset = 1;
      idle();
      chk("post_rst_fill", 64'(fill), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   task automatic idle_rdy();
      cyc(0, '0, '0, '0, 1);
   endtask
endmodule
`default_nettype wire
